// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and defaults for the register-file write-back arbiter
package wb_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int ZERO_REG       = 0;

  typedef enum logic {
    PRI_ALU,
    PRI_MEM
  } prio_state_e;

  typedef enum logic {
    SRC_ALU,
    SRC_MEM
  } src_e;

endpackage

// File: rtl/wb_prio_arbiter.sv
// rtl/wb_prio_arbiter.sv - ALU/MEM grant logic, priority FSM and MEM starve counter
// WB_STARVE_GUARD_EN enables the starve counter and PRI_MEM; otherwise ALU has fixed priority.
module wb_prio_arbiter
  import wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic alu_valid_i,
  input  logic mem_valid_i,
  output logic alu_ready_o,
  output logic mem_ready_o,
  output src_e grant_src_o
);

  prio_state_e state_q, state_d;
  logic        mem_first;
  logic        alu_grant;
  logic        mem_grant;

  if (STARVE_LIMIT < 1) begin : g_limit_check
    $error("STARVE_LIMIT must be at least 1");
  end

  // Grants depend only on valids and registered state; both forced low during reset.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (!Rst) begin
      if (mem_first) begin
        if (mem_valid_i)      mem_grant = 1'b1;
        else if (alu_valid_i) alu_grant = 1'b1;
      end else begin
        if (alu_valid_i)      alu_grant = 1'b1;
        else if (mem_valid_i) mem_grant = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= PRI_ALU;
    else     state_q <= state_d;
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int              SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q, starve_d;

  // Reaching the limit hands MEM priority in that same cycle, not one later.
  assign mem_first = (state_q == PRI_MEM) || (starve_q == LIMIT);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (!mem_valid_i || mem_grant) starve_d = '0;
    else if (starve_q != LIMIT)    starve_d = starve_q + SW'(1);
    case (state_q)
      PRI_ALU: if (starve_q == LIMIT && !mem_grant) state_d = PRI_MEM;
      PRI_MEM: if (mem_grant) state_d = PRI_ALU;
      default: state_d = PRI_ALU;
    endcase
  end
`else
  assign mem_first = (state_q == PRI_MEM);

  always_comb begin
    state_d = PRI_ALU;
  end
`endif

  assign alu_ready_o  = alu_grant;
  assign mem_ready_o  = mem_grant;
  assign grant_src_o  = mem_grant ? SRC_MEM : SRC_ALU;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-back port: arbitration, x0 filter, output stage
// WB_STARVE_GUARD_EN (in wb_prio_arbiter) selects starvation-guarded vs fixed ALU priority.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_ready,
  output logic                  write_En,
  output logic [ADDR_WIDTH-1:0] writeAddr,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [CNT_WIDTH-1:0]  commit_cnt
);

  src_e                  grant_src;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  wb_prio_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .Clk          (Clk),
    .Rst          (Rst),
    .alu_valid_i  (alu_valid),
    .mem_valid_i  (mem_valid),
    .alu_ready_o  (alu_ready),
    .mem_ready_o  (mem_ready),
    .grant_src_o  (grant_src)
  );

  assign xfer = alu_ready | mem_ready;

  always_comb begin
    sel_rd   = alu_rd;
    sel_data = alu_data;
    if (grant_src == SRC_MEM) begin
      sel_rd   = mem_rd;
      sel_data = mem_data;
    end
  end

  // x0 writes are accepted and counted but never reach the register file.
  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (xfer) begin
      we_d   = (sel_rd != ADDR_WIDTH'(ZERO_REG));
      addr_d = sel_rd;
      data_d = sel_data;
      cnt_d  = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign write_En   = we_q;
  assign writeAddr  = addr_q;
  assign data_in    = data_q;
  assign commit_cnt = cnt_q;

endmodule
